// File: rtl/prv664_iscoreboard_issue.sv
// prv664_iscoreboard_issue
// Dual-slot in-order issue stage. Checks RAW hazards of a decoded pair against
// the integer scoreboard (busy/id flags) and within the pair, allocates itags,
// drives the scoreboard update ports and registers issued instructions.
// A pair whose younger slot cannot issue is split: the younger slot is held
// (state HOLD) and retried as the next slot0 candidate.
// Optional feature macro: PRV664_ISSUE_BYPASS_EN (commit-port wakeup bypass).
//
// Handshakes: the input pair transfers on a cycle where in_valid_i and
// in_ready_o are both high; the source must keep the pair stable while
// in_valid_i is high and in_ready_o is low. The output register transfers on
// a cycle where a bit of out_valid_o and out_ready_i are both high; it holds
// its contents while out_valid_o != 0 and out_ready_i is low.
module prv664_iscoreboard_issue #(
  parameter int IDLEN = 8
) (
  input  logic                   clk_i,
  input  logic                   arstn_i,
  input  logic                   flush_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic                   in_v1_i,
  input  logic [1:0][4:0]        in_rs1_i,
  input  logic [1:0][4:0]        in_rs2_i,
  input  logic [1:0]             in_rs1en_i,
  input  logic [1:0]             in_rs2en_i,
  input  logic [1:0][4:0]        in_rd_i,
  input  logic [1:0]             in_rdwr_i,
  input  logic [31:0]            busy_flag_i,
  input  logic [31:0][IDLEN-1:0] id_flag_i,
  input  logic                   commit0_valid_i,
  input  logic                   commit0_wren_i,
  input  logic [4:0]             commit0_rdindex_i,
  input  logic [IDLEN-1:0]       commit0_itag_i,
  input  logic                   commit1_valid_i,
  input  logic                   commit1_wren_i,
  input  logic [4:0]             commit1_rdindex_i,
  input  logic [IDLEN-1:0]       commit1_itag_i,
  output logic                   isb_upd0_write_o,
  output logic [4:0]             isb_upd0_rdindex_o,
  output logic [IDLEN-1:0]       isb_upd0_itag_o,
  output logic                   isb_upd1_write_o,
  output logic [4:0]             isb_upd1_rdindex_o,
  output logic [IDLEN-1:0]       isb_upd1_itag_o,
  output logic [1:0]             out_valid_o,
  input  logic                   out_ready_i,
  output logic [1:0][IDLEN-1:0]  out_itag_o,
  output logic [1:0][4:0]        out_rd_o,
  output logic [1:0]             out_rdwr_o,
  output logic                   dbg_state_o   // 0 = IDLE, 1 = HOLD
);

  typedef enum logic {S_IDLE = 1'b0, S_HOLD = 1'b1} state_t;

  typedef struct packed {
    logic [4:0] rd;
    logic       rdwr;
    logic [4:0] rs1;
    logic       rs1en;
    logic [4:0] rs2;
    logic       rs2en;
  } instr_t;

  state_t           state_q, state_d;
  instr_t           held_q;
  logic [IDLEN-1:0] cnt_q;
  instr_t           in0, in1, cand0;
  logic             cand0_v, cand1_v;
  logic             ok0, ok1, raw01, out_free, fire0, fire1, split;
  logic [31:0]      reg_rdy;
  logic [IDLEN-1:0] itag1;

  function automatic logic srcs_ok(input instr_t x, input logic [31:0] rdy);
    return (!x.rs1en || rdy[x.rs1]) && (!x.rs2en || rdy[x.rs2]);
  endfunction

  function automatic logic reads_reg(input instr_t x, input logic [4:0] r);
    return (x.rs1en && (x.rs1 == r)) || (x.rs2en && (x.rs2 == r));
  endfunction

  assign in0 = '{rd: in_rd_i[0], rdwr: in_rdwr_i[0], rs1: in_rs1_i[0],
                 rs1en: in_rs1en_i[0], rs2: in_rs2_i[0], rs2en: in_rs2en_i[0]};
  assign in1 = '{rd: in_rd_i[1], rdwr: in_rdwr_i[1], rs1: in_rs1_i[1],
                 rs1en: in_rs1en_i[1], rs2: in_rs2_i[1], rs2en: in_rs2en_i[1]};

  // Per-register readiness: not busy, x0, or (bypass build) committing this cycle
  always_comb begin
    reg_rdy = ~busy_flag_i;
`ifdef PRV664_ISSUE_BYPASS_EN
    for (int i = 1; i < 32; i++) begin
      if ((commit0_valid_i && commit0_wren_i && (commit0_rdindex_i == 5'(i)) &&
           (commit0_itag_i == id_flag_i[i])) ||
          (commit1_valid_i && commit1_wren_i && (commit1_rdindex_i == 5'(i)) &&
           (commit1_itag_i == id_flag_i[i]))) begin
        reg_rdy[i] = 1'b1;
      end
    end
`endif
    reg_rdy[0] = 1'b1;
  end

`ifndef PRV664_ISSUE_BYPASS_EN
  // Commit ports and pending itags only matter for the wakeup bypass
  logic unused_bypass;
  assign unused_bypass = ^{commit0_valid_i, commit0_wren_i, commit0_rdindex_i, commit0_itag_i,
                           commit1_valid_i, commit1_wren_i, commit1_rdindex_i, commit1_itag_i,
                           id_flag_i};
`endif

  // Candidate selection, hazard checks and issue decisions
  always_comb begin
    cand0    = (state_q == S_HOLD) ? held_q : in0;
    cand0_v  = (state_q == S_HOLD) || in_valid_i;
    cand1_v  = (state_q == S_IDLE) && in_valid_i && in_v1_i;
    ok0      = srcs_ok(cand0, reg_rdy);
    raw01    = cand0.rdwr && (cand0.rd != 5'd0) && reads_reg(in1, cand0.rd);
    ok1      = srcs_ok(in1, reg_rdy) && !raw01;
    out_free = (out_valid_o == 2'b00) || out_ready_i;
    fire0    = cand0_v && ok0 && out_free && !flush_i;
    fire1    = fire0 && cand1_v && ok1;
    split    = (state_q == S_IDLE) && fire0 && cand1_v && !ok1;
    itag1    = cnt_q + IDLEN'(1);
    // Input is only taken when slot0 can go, so an accepted pair always issues slot0
    in_ready_o = arstn_i && (state_q == S_IDLE) && out_free && !flush_i &&
                 (!in_valid_i || ok0);
  end

  // Scoreboard update writes happen in the fire cycle; x0 never becomes busy
  always_comb begin
    isb_upd0_write_o   = fire0 && cand0.rdwr && (cand0.rd != 5'd0);
    isb_upd0_rdindex_o = cand0.rd;
    isb_upd0_itag_o    = cnt_q;
    isb_upd1_write_o   = fire1 && in1.rdwr && (in1.rd != 5'd0);
    isb_upd1_rdindex_o = in1.rd;
    isb_upd1_itag_o    = itag1;
  end

  // Next-state logic: split enters HOLD, issuing the held slot returns to IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (split) state_d = S_HOLD;
      S_HOLD: if (fire0) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush_i) state_d = S_IDLE;
  end

  assign dbg_state_o = state_q;

  // State register, held younger slot and itag counter
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q <= S_IDLE;
      held_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (split) held_q <= in1;
      cnt_q <= cnt_q + IDLEN'(fire0) + IDLEN'(fire1);
    end
  end

  // Output register: flush clears, issue loads, accepted output drains
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      out_valid_o <= '0;
      out_itag_o  <= '0;
      out_rd_o    <= '0;
      out_rdwr_o  <= '0;
    end else if (flush_i) begin
      out_valid_o <= '0;
    end else if (fire0) begin
      out_valid_o   <= {fire1, 1'b1};
      out_itag_o[0] <= cnt_q;
      out_itag_o[1] <= itag1;
      out_rd_o[0]   <= cand0.rd;
      out_rd_o[1]   <= in1.rd;
      out_rdwr_o[0] <= cand0.rdwr;
      out_rdwr_o[1] <= in1.rdwr;
    end else if (out_ready_i) begin
      out_valid_o <= '0;
    end
  end

endmodule

// File: tb/tb_prv664_iscoreboard_issue.sv
// Testbench for prv664_iscoreboard_issue: directed scenarios plus a randomized
// run checked against a queue-based reference model of the issue rules.
module tb_prv664_iscoreboard_issue;

  typedef struct packed {
    logic [4:0] rd;
    logic       rdwr;
    logic [4:0] rs1;
    logic       rs1en;
    logic [4:0] rs2;
    logic       rs2en;
  } ins_t;

  logic            clk_i = 1'b0;
  logic            arstn_i = 1'b0;
  logic            flush_i, in_valid_i, in_ready_o, in_v1_i;
  logic [1:0][4:0] in_rs1_i, in_rs2_i, in_rd_i;
  logic [1:0]      in_rs1en_i, in_rs2en_i, in_rdwr_i;
  logic [31:0]     busy_flag_i;
  logic [31:0][7:0] id_flag_i;
  logic            commit0_valid_i, commit0_wren_i, commit1_valid_i, commit1_wren_i;
  logic [4:0]      commit0_rdindex_i, commit1_rdindex_i;
  logic [7:0]      commit0_itag_i, commit1_itag_i;
  logic            isb_upd0_write_o, isb_upd1_write_o;
  logic [4:0]      isb_upd0_rdindex_o, isb_upd1_rdindex_o;
  logic [7:0]      isb_upd0_itag_o, isb_upd1_itag_o;
  logic [1:0]      out_valid_o;
  logic            out_ready_i;
  logic [1:0][7:0] out_itag_o;
  logic [1:0][4:0] out_rd_o;
  logic [1:0]      out_rdwr_o;
  logic            dbg_state_o;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  ins_t       m_hold[$];
  logic [1:0] m_ov;
  int         m_oitag[2];
  logic [4:0] m_ord[2];
  logic       m_ordwr[2];
  int         m_cnt;

  prv664_iscoreboard_issue #(.IDLEN(8)) dut (
    .clk_i(clk_i), .arstn_i(arstn_i), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_v1_i(in_v1_i),
    .in_rs1_i(in_rs1_i), .in_rs2_i(in_rs2_i), .in_rs1en_i(in_rs1en_i),
    .in_rs2en_i(in_rs2en_i), .in_rd_i(in_rd_i), .in_rdwr_i(in_rdwr_i),
    .busy_flag_i(busy_flag_i), .id_flag_i(id_flag_i),
    .commit0_valid_i(commit0_valid_i), .commit0_wren_i(commit0_wren_i),
    .commit0_rdindex_i(commit0_rdindex_i), .commit0_itag_i(commit0_itag_i),
    .commit1_valid_i(commit1_valid_i), .commit1_wren_i(commit1_wren_i),
    .commit1_rdindex_i(commit1_rdindex_i), .commit1_itag_i(commit1_itag_i),
    .isb_upd0_write_o(isb_upd0_write_o), .isb_upd0_rdindex_o(isb_upd0_rdindex_o),
    .isb_upd0_itag_o(isb_upd0_itag_o),
    .isb_upd1_write_o(isb_upd1_write_o), .isb_upd1_rdindex_o(isb_upd1_rdindex_o),
    .isb_upd1_itag_o(isb_upd1_itag_o),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_itag_o(out_itag_o),
    .out_rd_o(out_rd_o), .out_rdwr_o(out_rdwr_o), .dbg_state_o(dbg_state_o)
  );

  // Clock
  always #5 clk_i = ~clk_i;

  // ---------------- driver helpers ----------------
  function automatic ins_t mk(input int rd, input int rdwr, input int rs1, input int rs1en,
                              input int rs2, input int rs2en);
    ins_t x;
    x.rd = 5'(rd); x.rdwr = 1'(rdwr); x.rs1 = 5'(rs1); x.rs1en = 1'(rs1en);
    x.rs2 = 5'(rs2); x.rs2en = 1'(rs2en);
    return x;
  endfunction

  function automatic ins_t rand_ins();
    return mk($urandom_range(0, 15), $urandom_range(0, 1), $urandom_range(0, 15),
              $urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 1));
  endfunction

  task automatic set_ins(input int s, input ins_t x);
    in_rd_i[s] = x.rd; in_rdwr_i[s] = x.rdwr;
    in_rs1_i[s] = x.rs1; in_rs1en_i[s] = x.rs1en;
    in_rs2_i[s] = x.rs2; in_rs2en_i[s] = x.rs2en;
  endtask

  task automatic idle_inputs();
    flush_i = 0; in_valid_i = 0; in_v1_i = 0; out_ready_i = 1;
    set_ins(0, '0); set_ins(1, '0);
    busy_flag_i = '0; id_flag_i = '0;
    commit0_valid_i = 0; commit0_wren_i = 0; commit0_rdindex_i = '0; commit0_itag_i = '0;
    commit1_valid_i = 0; commit1_wren_i = 0; commit1_rdindex_i = '0; commit1_itag_i = '0;
  endtask

  task automatic step();
    @(posedge clk_i); #1;
  endtask

  task automatic do_reset();
    arstn_i = 0; idle_inputs();
    repeat (2) @(posedge clk_i);
    #1 arstn_i = 1;
  endtask

  // ---------------- model helpers ----------------
  function automatic bit reg_free(input logic [4:0] idx);
    if (idx == 5'd0) return 1;
    if (!busy_flag_i[idx]) return 1;
`ifdef PRV664_ISSUE_BYPASS_EN
    if (commit0_valid_i && commit0_wren_i && commit0_rdindex_i == idx &&
        commit0_itag_i == id_flag_i[idx]) return 1;
    if (commit1_valid_i && commit1_wren_i && commit1_rdindex_i == idx &&
        commit1_itag_i == id_flag_i[idx]) return 1;
`endif
    return 0;
  endfunction

  function automatic bit ins_ok(input ins_t x);
    return (!x.rs1en || reg_free(x.rs1)) && (!x.rs2en || reg_free(x.rs2));
  endfunction

  function automatic bit reads(input ins_t x, input logic [4:0] r);
    return (x.rs1en && x.rs1 == r) || (x.rs2en && x.rs2 == r);
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle_inputs(); arstn_i = 0; #3;
    n_cmp++; if (in_ready_o !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b want 0", in_ready_o); end
    n_cmp++; if (out_valid_o !== 2'b00) begin n_err++; $display("FAIL reset_out_valid: got %b want 00", out_valid_o); end
    n_cmp++; if ({isb_upd0_write_o, isb_upd1_write_o} !== 2'b00) begin n_err++; $display("FAIL reset_upd_write: got %b%b want 00", isb_upd0_write_o, isb_upd1_write_o); end
    n_cmp++; if (dbg_state_o !== 1'b0) begin n_err++; $display("FAIL reset_state: got %b want 0", dbg_state_o); end
    repeat (2) @(posedge clk_i);
    #1 arstn_i = 1; #1;
    n_cmp++; if (in_ready_o !== 1'b1) begin n_err++; $display("FAIL reset_ready_after: got %b want 1", in_ready_o); end
  endtask

  task automatic test_independent_pair();
    do_reset();
    set_ins(0, mk(1, 1, 2, 1, 0, 0)); set_ins(1, mk(3, 1, 4, 1, 0, 0));
    in_valid_i = 1; in_v1_i = 1; #1;
    n_cmp++; if (in_ready_o !== 1'b1) begin n_err++; $display("FAIL pair_ready: got %b want 1", in_ready_o); end
    n_cmp++; if ({isb_upd0_write_o, isb_upd0_rdindex_o, isb_upd0_itag_o} !== {1'b1, 5'd1, 8'd0}) begin n_err++; $display("FAIL pair_upd0: got w=%b rd=%0d tag=%0d want w=1 rd=1 tag=0", isb_upd0_write_o, isb_upd0_rdindex_o, isb_upd0_itag_o); end
    n_cmp++; if ({isb_upd1_write_o, isb_upd1_rdindex_o, isb_upd1_itag_o} !== {1'b1, 5'd3, 8'd1}) begin n_err++; $display("FAIL pair_upd1: got w=%b rd=%0d tag=%0d want w=1 rd=3 tag=1", isb_upd1_write_o, isb_upd1_rdindex_o, isb_upd1_itag_o); end
    step(); in_valid_i = 0; #1;
    n_cmp++; if (out_valid_o !== 2'b11) begin n_err++; $display("FAIL pair_out_valid: got %b want 11", out_valid_o); end
    n_cmp++; if ({out_itag_o[0], out_itag_o[1], out_rd_o[0], out_rd_o[1]} !== {8'd0, 8'd1, 5'd1, 5'd3}) begin n_err++; $display("FAIL pair_out_regs: got tags %0d/%0d rd %0d/%0d want 0/1 1/3", out_itag_o[0], out_itag_o[1], out_rd_o[0], out_rd_o[1]); end
  endtask

  task automatic test_split_hold();
    do_reset();
    set_ins(0, mk(5, 1, 0, 0, 0, 0)); set_ins(1, mk(6, 1, 5, 1, 0, 0));
    in_valid_i = 1; in_v1_i = 1; #1;
    n_cmp++; if (in_ready_o !== 1'b1) begin n_err++; $display("FAIL split_ready: got %b want 1", in_ready_o); end
    n_cmp++; if ({isb_upd0_write_o, isb_upd0_rdindex_o, isb_upd0_itag_o, isb_upd1_write_o} !== {1'b1, 5'd5, 8'd0, 1'b0}) begin n_err++; $display("FAIL split_upd: got w0=%b rd=%0d tag=%0d w1=%b want 1 5 0 0", isb_upd0_write_o, isb_upd0_rdindex_o, isb_upd0_itag_o, isb_upd1_write_o); end
    step(); in_valid_i = 0; busy_flag_i[5] = 1; #1;
    n_cmp++; if (dbg_state_o !== 1'b1) begin n_err++; $display("FAIL split_hold_state: got %b want 1", dbg_state_o); end
    n_cmp++; if ({out_valid_o, out_itag_o[0], out_rd_o[0]} !== {2'b01, 8'd0, 5'd5}) begin n_err++; $display("FAIL split_out0: got v=%b tag=%0d rd=%0d want 01 0 5", out_valid_o, out_itag_o[0], out_rd_o[0]); end
    n_cmp++; if ({in_ready_o, isb_upd0_write_o} !== 2'b00) begin n_err++; $display("FAIL split_hold_blocked: got rdy=%b w0=%b want 0 0", in_ready_o, isb_upd0_write_o); end
    step(); busy_flag_i[5] = 0; #1;
    n_cmp++; if ({isb_upd0_write_o, isb_upd0_rdindex_o, isb_upd0_itag_o} !== {1'b1, 5'd6, 8'd1}) begin n_err++; $display("FAIL split_held_upd: got w=%b rd=%0d tag=%0d want 1 6 1", isb_upd0_write_o, isb_upd0_rdindex_o, isb_upd0_itag_o); end
    step(); #1;
    n_cmp++; if ({dbg_state_o, in_ready_o, out_valid_o, out_itag_o[0], out_rd_o[0]} !== {1'b0, 1'b1, 2'b01, 8'd1, 5'd6}) begin n_err++; $display("FAIL split_held_out: got st=%b rdy=%b v=%b tag=%0d rd=%0d want 0 1 01 1 6", dbg_state_o, in_ready_o, out_valid_o, out_itag_o[0], out_rd_o[0]); end
  endtask

  task automatic test_busy_stall();
    do_reset();
    busy_flag_i[7] = 1; set_ins(0, mk(8, 1, 7, 1, 0, 0)); in_valid_i = 1; #1;
    for (int c = 0; c < 3; c++) begin
      n_cmp++; if ({in_ready_o, isb_upd0_write_o, isb_upd1_write_o, out_valid_o} !== 5'b0) begin n_err++; $display("FAIL stall_cycle%0d: got rdy=%b w=%b%b v=%b want all 0", c, in_ready_o, isb_upd0_write_o, isb_upd1_write_o, out_valid_o); end
      step(); #1;
    end
    busy_flag_i[7] = 0; #1;
    n_cmp++; if ({in_ready_o, isb_upd0_write_o, isb_upd0_rdindex_o, isb_upd0_itag_o} !== {2'b11, 5'd8, 8'd0}) begin n_err++; $display("FAIL stall_release: got rdy=%b w=%b rd=%0d tag=%0d want 1 1 8 0", in_ready_o, isb_upd0_write_o, isb_upd0_rdindex_o, isb_upd0_itag_o); end
    step(); in_valid_i = 0; #1;
    n_cmp++; if ({out_valid_o, out_rd_o[0]} !== {2'b01, 5'd8}) begin n_err++; $display("FAIL stall_out: got v=%b rd=%0d want 01 8", out_valid_o, out_rd_o[0]); end
  endtask

  task automatic test_itag_wrap();
    do_reset();
    set_ins(0, mk(1, 1, 0, 0, 0, 0)); set_ins(1, mk(2, 1, 0, 0, 0, 0));
    in_valid_i = 1; in_v1_i = 1;
    repeat (127) step();          // 127 pairs -> counter 254
    in_v1_i = 0; step();          // one single -> counter 255
    in_v1_i = 1; #1;
    n_cmp++; if ({isb_upd0_itag_o, isb_upd1_itag_o} !== {8'd255, 8'd0}) begin n_err++; $display("FAIL wrap_upd_tags: got %0d/%0d want 255/0", isb_upd0_itag_o, isb_upd1_itag_o); end
    step(); in_v1_i = 0; #1;
    n_cmp++; if ({out_valid_o, out_itag_o[0], out_itag_o[1]} !== {2'b11, 8'd255, 8'd0}) begin n_err++; $display("FAIL wrap_out_tags: got v=%b %0d/%0d want 11 255/0", out_valid_o, out_itag_o[0], out_itag_o[1]); end
    n_cmp++; if (isb_upd0_itag_o !== 8'd1) begin n_err++; $display("FAIL wrap_next_tag: got %0d want 1", isb_upd0_itag_o); end
  endtask

  // Leaves the DUT in HOLD with out_valid_o=01 and the output stalled
  task automatic enter_hold_stalled();
    do_reset();
    set_ins(0, mk(5, 1, 0, 0, 0, 0)); set_ins(1, mk(6, 1, 5, 1, 0, 0));
    in_valid_i = 1; in_v1_i = 1;
    step(); in_valid_i = 0; out_ready_i = 0;
  endtask

  task automatic test_flush_hold();
    enter_hold_stalled(); #1;
    n_cmp++; if ({dbg_state_o, out_valid_o, isb_upd0_write_o} !== {1'b1, 2'b01, 1'b0}) begin n_err++; $display("FAIL flush_pre: got st=%b v=%b w=%b want 1 01 0", dbg_state_o, out_valid_o, isb_upd0_write_o); end
    flush_i = 1; #1;
    n_cmp++; if ({isb_upd0_write_o, isb_upd1_write_o} !== 2'b00) begin n_err++; $display("FAIL flush_no_write: got %b%b want 00", isb_upd0_write_o, isb_upd1_write_o); end
    step(); flush_i = 0; #1;
    n_cmp++; if ({out_valid_o, dbg_state_o, in_ready_o} !== {2'b00, 1'b0, 1'b1}) begin n_err++; $display("FAIL flush_after: got v=%b st=%b rdy=%b want 00 0 1", out_valid_o, dbg_state_o, in_ready_o); end
    out_ready_i = 1; set_ins(0, mk(10, 1, 0, 0, 0, 0)); in_valid_i = 1; in_v1_i = 0; #1;
    n_cmp++; if ({isb_upd0_write_o, isb_upd0_itag_o} !== {1'b1, 8'd1}) begin n_err++; $display("FAIL flush_cnt_kept: got w=%b tag=%0d want 1 1", isb_upd0_write_o, isb_upd0_itag_o); end
  endtask

  task automatic test_reset_mid();
    enter_hold_stalled(); #2;
    arstn_i = 0; #1;
    n_cmp++; if ({out_valid_o, dbg_state_o, in_ready_o, isb_upd0_write_o} !== 5'b0) begin n_err++; $display("FAIL midreset_state: got v=%b st=%b rdy=%b w=%b want all 0", out_valid_o, dbg_state_o, in_ready_o, isb_upd0_write_o); end
    @(posedge clk_i); #1 arstn_i = 1;
    out_ready_i = 1; set_ins(0, mk(3, 1, 0, 0, 0, 0)); in_valid_i = 1; in_v1_i = 0; #1;
    n_cmp++; if ({isb_upd0_write_o, isb_upd0_itag_o} !== {1'b1, 8'd0}) begin n_err++; $display("FAIL midreset_cnt: got w=%b tag=%0d want 1 0", isb_upd0_write_o, isb_upd0_itag_o); end
  endtask

  task automatic test_bypass();
    bit byp;
    int exp_tag;
`ifdef PRV664_ISSUE_BYPASS_EN
    byp = 1;
`else
    byp = 0;
`endif
    do_reset();
    busy_flag_i[9] = 1; id_flag_i[9] = 8'd4;
    commit0_valid_i = 1; commit0_wren_i = 1; commit0_rdindex_i = 5'd9; commit0_itag_i = 8'd4;
    set_ins(0, mk(11, 1, 9, 1, 0, 0)); in_valid_i = 1; #1;
    n_cmp++; if ({in_ready_o, isb_upd0_write_o} !== {byp, byp}) begin n_err++; $display("FAIL bypass_wakeup: got rdy=%b w=%b want %b %b", in_ready_o, isb_upd0_write_o, byp, byp); end
    step(); busy_flag_i[9] = 0; commit0_valid_i = 0; #1;
    exp_tag = byp ? 1 : 0;
    n_cmp++; if ({isb_upd0_write_o, isb_upd0_itag_o} !== {1'b1, 8'(exp_tag)}) begin n_err++; $display("FAIL bypass_after_clear: got w=%b tag=%0d want 1 %0d", isb_upd0_write_o, isb_upd0_itag_o, exp_tag); end
  endtask

  task automatic test_random(input int ncyc);
    ins_t s0, s1, c0;
    bit keep, h0, h1, ok0, ok1, ofree, i0, i1, e_rdy, e_w0, e_w1, v, v1;
    do_reset();
    m_hold.delete(); m_ov = 2'b00; m_cnt = 0; keep = 0;
    s0 = '0; s1 = '0; v = 0; v1 = 0;
    for (int c = 0; c < ncyc; c++) begin
      if (!keep) begin
        v = ($urandom_range(0, 3) != 0); v1 = $urandom_range(0, 1) == 1;
        s0 = rand_ins(); s1 = rand_ins();
      end
      in_valid_i = v; in_v1_i = v1; set_ins(0, s0); set_ins(1, s1);
      for (int i = 1; i < 32; i++) begin
        busy_flag_i[i] = ($urandom_range(0, 4) == 0);
        id_flag_i[i] = 8'($urandom_range(0, 3));
      end
      busy_flag_i[0] = 0;
      commit0_valid_i = $urandom_range(0, 1) == 1; commit0_wren_i = $urandom_range(0, 3) != 0;
      commit0_rdindex_i = 5'($urandom_range(1, 15));
      commit0_itag_i = $urandom_range(0, 1) ? id_flag_i[commit0_rdindex_i] : 8'($urandom_range(0, 3));
      commit1_valid_i = $urandom_range(0, 1) == 1; commit1_wren_i = $urandom_range(0, 3) != 0;
      commit1_rdindex_i = 5'($urandom_range(1, 15));
      commit1_itag_i = $urandom_range(0, 1) ? id_flag_i[commit1_rdindex_i] : 8'($urandom_range(0, 3));
      flush_i = ($urandom_range(0, 19) == 0); out_ready_i = ($urandom_range(0, 3) != 0);
      #2;
      // model: oldest pending instruction first, younger slot only from a fresh pair
      h0 = (m_hold.size() != 0) || v;
      c0 = (m_hold.size() != 0) ? m_hold[0] : s0;
      h1 = (m_hold.size() == 0) && v && v1;
      ok0 = h0 && ins_ok(c0);
      ok1 = h1 && ins_ok(s1) && !(c0.rdwr && c0.rd != 0 && reads(s1, c0.rd));
      ofree = (m_ov == 2'b00) || out_ready_i;
      i0 = ok0 && ofree && !flush_i;
      i1 = i0 && ok1;
      e_rdy = (m_hold.size() == 0) && ofree && !flush_i && (!v || ok0);
      e_w0 = i0 && c0.rdwr && c0.rd != 0;
      e_w1 = i1 && s1.rdwr && s1.rd != 0;
      n_cmp++; if (in_ready_o !== e_rdy) begin n_err++; $display("FAIL rnd_ready c%0d: got %b want %b", c, in_ready_o, e_rdy); end
      n_cmp++; if ({isb_upd0_write_o, isb_upd1_write_o} !== {e_w0, e_w1}) begin n_err++; $display("FAIL rnd_writes c%0d: got %b%b want %b%b", c, isb_upd0_write_o, isb_upd1_write_o, e_w0, e_w1); end
      if (e_w0) begin
        n_cmp++; if ({isb_upd0_rdindex_o, isb_upd0_itag_o} !== {c0.rd, 8'(m_cnt)}) begin n_err++; $display("FAIL rnd_upd0 c%0d: got rd=%0d tag=%0d want %0d %0d", c, isb_upd0_rdindex_o, isb_upd0_itag_o, c0.rd, m_cnt); end
      end
      if (e_w1) begin
        n_cmp++; if ({isb_upd1_rdindex_o, isb_upd1_itag_o} !== {s1.rd, 8'((m_cnt + 1) % 256)}) begin n_err++; $display("FAIL rnd_upd1 c%0d: got rd=%0d tag=%0d want %0d %0d", c, isb_upd1_rdindex_o, isb_upd1_itag_o, s1.rd, (m_cnt + 1) % 256); end
      end
      keep = v && !e_rdy;
      @(posedge clk_i);
      if (flush_i) begin
        m_ov = 2'b00; m_hold.delete();
      end else if (i0) begin
        m_ov = {i1, 1'b1};
        m_oitag[0] = m_cnt; m_ord[0] = c0.rd; m_ordwr[0] = c0.rdwr;
        m_oitag[1] = (m_cnt + 1) % 256; m_ord[1] = s1.rd; m_ordwr[1] = s1.rdwr;
        m_cnt = (m_cnt + 1 + int'(i1)) % 256;
        if (m_hold.size() != 0) void'(m_hold.pop_front());
        else if (h1 && !i1) m_hold.push_back(s1);
      end else if (out_ready_i) begin
        m_ov = 2'b00;
      end
      #1;
      n_cmp++; if (out_valid_o !== m_ov) begin n_err++; $display("FAIL rnd_out_valid c%0d: got %b want %b", c, out_valid_o, m_ov); end
      n_cmp++; if (dbg_state_o !== (m_hold.size() != 0)) begin n_err++; $display("FAIL rnd_state c%0d: got %b want %b", c, dbg_state_o, m_hold.size() != 0); end
      for (int s = 0; s < 2; s++) begin
        if (m_ov[s]) begin
          n_cmp++; if ({out_itag_o[s], out_rd_o[s], out_rdwr_o[s]} !== {8'(m_oitag[s]), m_ord[s], m_ordwr[s]}) begin n_err++; $display("FAIL rnd_out_slot%0d c%0d: got tag=%0d rd=%0d wr=%b want %0d %0d %b", s, c, out_itag_o[s], out_rd_o[s], out_rdwr_o[s], m_oitag[s], m_ord[s], m_ordwr[s]); end
        end
      end
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_independent_pair();
    test_split_hold();
    test_busy_stall();
    test_itag_wrap();
    test_flush_hold();
    test_reset_mid();
    test_bypass();
    test_random(3000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
